// File: rtl/qsys_pio_pkg.sv
// Shared constants and types for the qsys_pio_irq parallel I/O slave:
// register addresses, edge-capture polarity and the bus word width.
package qsys_pio_pkg;

   localparam int MAX_WIDTH = 32;

   localparam logic [2:0] ADDR_DATA         = 3'd0;
   localparam logic [2:0] ADDR_OUT          = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
   localparam logic [2:0] ADDR_OUTSET       = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_type_e;

endpackage

// File: rtl/pio_sync_edge.sv
// Input conditioning for the PIO: multi-flop synchroniser, one-cycle history
// register and a warm-up counter that masks the edges seen while the chain fills.
module pio_sync_edge
   import qsys_pio_pkg::*;
#(
   parameter int WIDTH       = 10,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pins_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] edges_o
);

   localparam int WARM_MAX = SYNC_STAGES + 1;
   localparam int CNT_W    = $clog2(WARM_MAX + 1);

   logic [WIDTH-1:0] syncChain_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;
   logic [CNT_W-1:0] warmCnt_q;
   logic [CNT_W-1:0] warmCnt_d;
   logic             warmDone;
   logic [WIDTH-1:0] rawEdges;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            syncChain_q[i] <= '0;
         end
         prev_q    <= '0;
         warmCnt_q <= '0;
      end else begin
         syncChain_q[0] <= pins_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            syncChain_q[i] <= syncChain_q[i-1];
         end
         prev_q    <= syncChain_q[SYNC_STAGES-1];
         warmCnt_q <= warmCnt_d;
      end
   end

   // Counter saturates once prev_q holds real synchronised data.
   assign warmDone  = (warmCnt_q == CNT_W'(WARM_MAX));
   assign warmCnt_d = warmDone ? warmCnt_q : warmCnt_q + CNT_W'(1);
   assign sync_o    = syncChain_q[SYNC_STAGES-1];

   always_comb begin
      rawEdges = sync_o & ~prev_q;
      if (EDGE_TYPE == int'(EDGE_FALL)) begin
         rawEdges = ~sync_o & prev_q;
      end else if (EDGE_TYPE == int'(EDGE_ANY)) begin
         rawEdges = sync_o ^ prev_q;
      end
   end

   assign edges_o = warmDone ? rawEdges : '0;

endmodule

// File: rtl/qsys_pio_irq.sv
// Avalon-MM parallel I/O slave: output register with atomic set/clear,
// synchronised input, per-bit edge capture and a maskable registered interrupt.
module qsys_pio_irq
   import qsys_pio_pkg::*;
#(
   parameter int                   WIDTH       = 10,
   parameter logic [MAX_WIDTH-1:0] RESET_VALUE = 32'h3FF,
   parameter int                   EDGE_TYPE   = 0,
   parameter int                   SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [2:0]           address,
   input  logic                 chipselect,
   input  logic                 write_n,
   input  logic [MAX_WIDTH-1:0] writedata,
   output logic [MAX_WIDTH-1:0] readdata,
   input  logic [WIDTH-1:0]     in_port,
   output logic [WIDTH-1:0]     out_port,
   output logic                 irq
);

   logic                 wrEn;
   logic                 rdEn;
   logic [WIDTH-1:0]     wData;
   logic                 unusedWriteBits;
   logic [WIDTH-1:0]     syncIn;
   logic [WIDTH-1:0]     edges;
   logic [WIDTH-1:0]     out_q, out_d;
   logic [WIDTH-1:0]     mask_q, mask_d;
   logic [WIDTH-1:0]     capture_q, capture_d;
   logic [WIDTH-1:0]     clearBits;
   logic                 irq_q, irq_d;
   logic [MAX_WIDTH-1:0] rdWord;

   assign wrEn            = chipselect & ~write_n;
   assign rdEn            = chipselect & write_n;
   assign wData           = writedata[WIDTH-1:0];
   assign unusedWriteBits = ^writedata;

   pio_sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync_edge (
      .clk     (clk),
      .rst_n   (reset_n),
      .pins_i  (in_port),
      .sync_o  (syncIn),
      .edges_o (edges)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q     <= RESET_VALUE[WIDTH-1:0];
         mask_q    <= '0;
         capture_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         out_q     <= out_d;
         mask_q    <= mask_d;
         capture_q <= capture_d;
         irq_q     <= irq_d;
      end
   end

   // A fresh edge is OR-ed in after the W1C clear so it survives a same-cycle clear.
   always_comb begin
      out_d     = out_q;
      mask_d    = mask_q;
      clearBits = '0;
      if (wrEn) begin
         case (address)
            ADDR_DATA, ADDR_OUT: out_d     = wData;
            ADDR_IRQ_MASK:       mask_d    = wData;
            ADDR_EDGE_CAPTURE:   clearBits = wData;
            ADDR_OUTSET:         out_d     = out_q | wData;
            ADDR_OUTCLEAR:       out_d     = out_q & ~wData;
            default:             ;
         endcase
      end
      capture_d = (capture_q & ~clearBits) | edges;
      irq_d     = |(capture_q & mask_q);
   end

   always_comb begin
      rdWord = '0;
      if (rdEn) begin
         case (address)
            ADDR_DATA:         rdWord[WIDTH-1:0] = syncIn;
            ADDR_OUT:          rdWord[WIDTH-1:0] = out_q;
            ADDR_IRQ_MASK:     rdWord[WIDTH-1:0] = mask_q;
            ADDR_EDGE_CAPTURE: rdWord[WIDTH-1:0] = capture_q;
            default:           rdWord = '0;
         endcase
      end
   end

   assign readdata = rdWord;
   assign out_port = out_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_qsys_pio_irq.sv
// Directed bench for qsys_pio_irq: a rising-edge and an any-edge instance share
// one bus and input pins, checked against hand-computed values.
module tb_qsys_pio_irq;

   logic        clk = 1'b0;
   logic        resetN;
   logic [2:0]  address;
   logic        chipselect;
   logic        writeN;
   logic [31:0] writedata;
   logic [9:0]  inPort;
   logic [31:0] readdata,  readdataAny;
   logic [9:0]  outPort,   outPortAny;
   logic        irqOut,    irqAny;

   int testCount = 0;
   int failCount = 0;
   logic [31:0] rd, rdAny;

   always #5 clk = ~clk;

   qsys_pio_irq #(
      .WIDTH(10), .RESET_VALUE(32'h3FF), .EDGE_TYPE(0), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .reset_n(resetN), .address(address), .chipselect(chipselect),
      .write_n(writeN), .writedata(writedata), .readdata(readdata),
      .in_port(inPort), .out_port(outPort), .irq(irqOut)
   );

   qsys_pio_irq #(
      .WIDTH(10), .RESET_VALUE(32'h3FF), .EDGE_TYPE(2), .SYNC_STAGES(2)
   ) dutAny (
      .clk(clk), .reset_n(resetN), .address(address), .chipselect(chipselect),
      .write_n(writeN), .writedata(writedata), .readdata(readdataAny),
      .in_port(inPort), .out_port(outPortAny), .irq(irqAny)
   );

   // Leaves the bench 1 time unit after a rising edge, away from the sampling point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle bus write; the write commits at the edge inside tick().
   task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
      address    = addr;
      writedata  = data;
      chipselect = 1'b1;
      writeN     = 1'b0;
      tick();
      chipselect = 1'b0;
      writeN     = 1'b1;
      writedata  = '0;
   endtask

   // Zero-wait-state combinational read of both instances.
   task automatic readReg(input logic [2:0] addr, output logic [31:0] d, output logic [31:0] dAny);
      address    = addr;
      chipselect = 1'b1;
      writeN     = 1'b1;
      #1;
      d          = readdata;
      dAny       = readdataAny;
      chipselect = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      resetN     = 1'b1;
      address    = '0;
      chipselect = 1'b0;
      writeN     = 1'b1;
      writedata  = '0;
      inPort     = 10'h3FF;
      #2 resetN  = 1'b0;
      tick();
      tick();
      checkOutput("reset out_port", 32'(outPort), 32'h3FF);
      checkOutput("reset irq", 32'(irqOut), 32'h0);
      checkOutput("reset readdata unselected", readdata, 32'h0);

      // Release reset with inputs already high: warm-up must hide the chain fill.
      resetN = 1'b1;
      repeat (5) tick();
      readReg(3'd2, rd, rdAny);
      checkOutput("post-reset mask", rd, 32'h0);
      readReg(3'd3, rd, rdAny);
      checkOutput("post-reset capture rise", rd, 32'h0);
      checkOutput("post-reset capture any", rdAny, 32'h0);
      readReg(3'd0, rd, rdAny);
      checkOutput("data reads pins", rd, 32'h3FF);

      // Falling edges on every bit: only the any-edge instance captures.
      inPort = 10'h000;
      repeat (4) tick();
      readReg(3'd3, rd, rdAny);
      checkOutput("fall ignored by rise", rd, 32'h0);
      checkOutput("fall captured by any", rdAny, 32'h3FF);
      applyStimulus(3'd3, 32'h3FF);
      readReg(3'd3, rd, rdAny);
      checkOutput("w1c all any", rdAny, 32'h0);

      applyStimulus(3'd1, 32'h155);
      checkOutput("out write", 32'(outPort), 32'h155);
      applyStimulus(3'd4, 32'h00A);
      checkOutput("outset", 32'(outPort), 32'h15F);
      applyStimulus(3'd5, 32'h101);
      checkOutput("outclear", 32'(outPort), 32'h05E);
      readReg(3'd1, rd, rdAny);
      checkOutput("read out", rd, 32'h05E);
      readReg(3'd4, rd, rdAny);
      checkOutput("read outset zero", rd, 32'h0);
      readReg(3'd5, rd, rdAny);
      checkOutput("read outclear zero", rd, 32'h0);

      applyStimulus(3'd2, 32'h001);
      readReg(3'd2, rd, rdAny);
      checkOutput("mask readback", rd, 32'h001);

      // Bit0 rises before edge k.
      inPort = 10'h001;
      tick();
      readReg(3'd0, rd, rdAny);
      checkOutput("data after k", rd, 32'h0);
      tick();
      readReg(3'd0, rd, rdAny);
      checkOutput("data after k+1", rd, 32'h001);
      readReg(3'd3, rd, rdAny);
      checkOutput("capture after k+1", rd, 32'h0);
      tick();
      readReg(3'd3, rd, rdAny);
      checkOutput("capture after k+2", rd, 32'h001);
      checkOutput("irq after k+2", 32'(irqOut), 32'h0);
      tick();
      checkOutput("irq after k+3", 32'(irqOut), 32'h1);
      checkOutput("irq any after k+3", 32'(irqAny), 32'h1);

      // New bit0 rise detected in the same cycle as its W1C clear.
      inPort = 10'h000;
      repeat (4) tick();
      inPort = 10'h001;
      tick();
      tick();
      applyStimulus(3'd3, 32'h001);
      readReg(3'd3, rd, rdAny);
      checkOutput("edge beats w1c", rd, 32'h001);
      checkOutput("irq held on w1c race", 32'(irqOut), 32'h1);
      tick();
      checkOutput("irq still set", 32'(irqOut), 32'h1);
      applyStimulus(3'd3, 32'h001);
      readReg(3'd3, rd, rdAny);
      checkOutput("capture cleared", rd, 32'h0);
      checkOutput("irq lags clear", 32'(irqOut), 32'h1);
      tick();
      checkOutput("irq drops", 32'(irqOut), 32'h0);
      checkOutput("irq any drops", 32'(irqAny), 32'h0);

      // Bit3 high for three cycles; clear after the rise, before the fall lands.
      inPort = 10'h009;
      tick();
      tick();
      tick();
      readReg(3'd3, rd, rdAny);
      checkOutput("bit3 rise", rd, 32'h008);
      checkOutput("bit3 rise any", rdAny, 32'h008);
      inPort = 10'h001;
      applyStimulus(3'd3, 32'h008);
      tick();
      tick();
      readReg(3'd3, rd, rdAny);
      checkOutput("bit3 fall rise-only", rd, 32'h0);
      checkOutput("bit3 fall any", rdAny, 32'h008);
      tick();
      checkOutput("masked bit3 irq any", 32'(irqAny), 32'h0);
      applyStimulus(3'd2, 32'h008);
      checkOutput("irq lags mask", 32'(irqAny), 32'h0);
      tick();
      checkOutput("irq after mask any", 32'(irqAny), 32'h1);
      checkOutput("irq after mask rise", 32'(irqOut), 32'h0);

      // Writes to the unused address change nothing; then an async reset mid-cycle.
      applyStimulus(3'd6, 32'hFFFF_FFFF);
      checkOutput("addr6 write out", 32'(outPort), 32'h05E);
      readReg(3'd2, rd, rdAny);
      checkOutput("addr6 write mask", rd, 32'h008);
      readReg(3'd6, rd, rdAny);
      checkOutput("addr6 read", rd, 32'h0);
      #2 resetN = 1'b0;
      #1;
      checkOutput("async reset out", 32'(outPort), 32'h3FF);
      checkOutput("async reset irq", 32'(irqAny), 32'h0);
      readReg(3'd3, rd, rdAny);
      checkOutput("async reset capture", rdAny, 32'h0);
      readReg(3'd2, rd, rdAny);
      checkOutput("async reset mask", rd, 32'h0);
      tick();
      resetN = 1'b1;
      repeat (5) tick();
      readReg(3'd3, rd, rdAny);
      checkOutput("warm-up restart rise", rd, 32'h0);
      checkOutput("warm-up restart any", rdAny, 32'h0);
      readReg(3'd0, rd, rdAny);
      checkOutput("data after restart", rd, 32'h001);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
